// File: rtl/demux_1x2_x64_buf_pkg.sv
// Shared types and defaults for the 1-to-2 steering demux.
// Lane enum, word type and FIFO sizing.
package demux_pkg;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

// File: rtl/demux_1x2_x64_buf_lane_fifo.sv
// Single-lane synchronous FIFO for the steering demux.
// Registered head, no bypass; flush clears pointers only.
module lane_fifo_x64
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = demux_pkg::DEPTH,
  localparam int CNTW = $clog2(DEPTH) + 1,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CNTW-1:0]  cnt;

  // Storage, pointers and occupancy; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      cnt <= cnt + CNTW'(push) - CNTW'(pop);
    end
  end

  // Head word and status flags straight from registered state.
  always_comb begin
    rdata = mem[rptr];
    count = cnt;
    full  = (cnt == CNTW'(DEPTH));
    empty = (cnt == '0);
  end

endmodule

// File: rtl/demux_1x2_x64_buf.sv
// Registered 1-to-2 demux: steers each word into a per-lane FIFO
// and hands each lane to its own consumer via valid/ready.
module demux_1x2_x64_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = demux_pkg::DEPTH,
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic [1:0]            out_valid,
  input  logic [1:0]            out_ready,
  output logic [1:0][WIDTH-1:0] out_data,
  output logic [1:0][CNTW-1:0]  count
);

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic       take;

  // Ready select, steering decode and per-lane pop handshake.
  always_comb begin
    in_ready  = !full[in_sel] && !reset && !flush;
    take      = in_valid && in_ready;
    push[0]   = take && (lane_e'(in_sel) == LANE0);
    push[1]   = take && (lane_e'(in_sel) == LANE1);
    out_valid = ~empty;
    pop       = out_valid & out_ready;
  end

  lane_fifo_x64 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) lane0 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push[0]),
    .wdata (in_data),
    .pop   (pop[0]),
    .rdata (out_data[0]),
    .count (count[0]),
    .full  (full[0]),
    .empty (empty[0])
  );

  lane_fifo_x64 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) lane1 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push[1]),
    .wdata (in_data),
    .pop   (pop[1]),
    .rdata (out_data[1]),
    .count (count[1]),
    .full  (full[1]),
    .empty (empty[1])
  );

endmodule
